pipe_ctrl: RTL and testbench

Parametrised pipeline controller for the five-stage MIPS core. It is the successor to the purely combinational stall unit. It arbitrates per-stage stall and flush requests into hold/bubble/flush vectors and tracks a valid bit for every stage register. It also runs an internal multi-cycle stall sequencer for long-latency EX operations (mul/div) and keeps saturating stall/flush performance counters. It sits beside the stage modules and drives their stall bus.

---
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush arbitration, stage valid tracking, multi-cycle stall sequencer and perf counters
module pipe_ctrl #(
  parameter int STAGES   = 6,
  parameter int MC_STAGE = 3,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STAGES-1:0]     stallreq,
  input  logic [STAGES-1:0]     flushreq,
  input  logic [STAGES*32-1:0]  flush_pc,
  input  logic                  mc_start,
  input  logic [7:0]            mc_len,
  input  logic                  perf_clr,
  output logic [STAGES-1:0]     stall,
  output logic [STAGES-1:0]     bubble,
  output logic [STAGES-1:0]     flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic [STAGES-1:0]     stage_valid,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [STAGES-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [STAGES-1:0]  stall_eff;
  logic               any_s, any_f, stall_win, flush_win, kill;
  int                 s_idx, f_idx;
  assign mc_busy     = state_q == BUSY;
  assign mc_done     = state_q == DONE;
  assign stage_valid = valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  // Find the oldest stalling and flushing stages and pick the winner; outputs are silenced in reset
  always_comb begin
    stall_eff = stallreq | (STAGES'(mc_busy) << MC_STAGE);
    any_s = 1'b0;
    any_f = 1'b0;
    s_idx = 0;
    f_idx = 0;
    for (int i = 0; i < STAGES; i++) begin
      if (stall_eff[i]) begin
        s_idx = i;
        any_s = 1'b1;
      end
      if (flushreq[i]) begin
        f_idx = i;
        any_f = 1'b1;
      end
    end
    flush_win = rst && any_f && (!any_s || s_idx <= f_idx);
    stall_win = rst && any_s && !flush_win;
    kill      = flush_win && f_idx >= MC_STAGE;
    for (int j = 0; j < STAGES; j++) begin
      stall[j]  = stall_win && j <= s_idx;
      bubble[j] = stall_win && j == s_idx + 1;
      flush[j]  = flush_win && j >= 1 && j <= f_idx;
    end
    redirect_valid = flush_win;
    redirect_pc    = flush_win ? flush_pc[f_idx*32 +: 32] : 32'd0;
  end
  // Next valid bits: held stages keep theirs, the bubble slot clears, flushed stages clear, the rest shift
  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = stall_win ? valid_q[0] : 1'b1;
    for (int j = 1; j < STAGES; j++)
      valid_d[j] = stall_win ? (j <= s_idx ? valid_q[j] : (j == s_idx + 1 ? 1'b0 : valid_q[j-1]))
                 : flush_win ? (j <= f_idx ? 1'b0 : valid_q[j-1])
                 : valid_q[j-1];
  end
  // Sequencer next state; a flush at or beyond the stalled stage aborts the operation without a done pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (mc_start) begin
          state_d = mc_len == 8'd0 ? DONE : BUSY;
          cnt_d   = mc_len;
        end
        BUSY: begin
          cnt_d   = cnt_q - 8'd1;
          state_d = cnt_q == 8'd1 ? DONE : BUSY;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Saturating counters; clear beats increment
  always_comb begin
    stall_cnt_d = perf_clr ? '0 : (stall_win && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = perf_clr ? '0 : (flush_win && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stallreq, flushreq;
  logic [191:0] flush_pc;
  logic         mc_start, perf_clr;
  logic [7:0]   mc_len;
  logic [5:0]   stall, bubble, flush, stage_valid;
  logic         redirect_valid, mc_busy, mc_done;
  logic [31:0]  redirect_pc, stall_cnt, flush_cnt;
  logic [5:0]   s_stall, s_bubble, s_flush, s_stage_valid;
  logic         s_redirect_valid, s_mc_busy, s_mc_done;
  logic [31:0]  s_redirect_pc;
  logic [3:0]   s_stall_cnt, s_flush_cnt;
  int           passed = 0, total = 0, failed = 0;
  logic [5:0]   mv, n_mv;
  int           rem, n_rem;
  bit           mdone, n_mdone;
  longint       msc, mfc, n_msc, n_mfc;
  int           msc4, mfc4, n_msc4, n_mfc4;

  always #5 clk = ~clk;

  pipe_ctrl dut (.clk(clk), .rst(rst), .stallreq(stallreq), .flushreq(flushreq), .flush_pc(flush_pc),
    .mc_start(mc_start), .mc_len(mc_len), .perf_clr(perf_clr), .stall(stall), .bubble(bubble),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stage_valid(stage_valid),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_ctrl #(.CNT_W(4)) dut_s (.clk(clk), .rst(rst), .stallreq(stallreq), .flushreq(flushreq),
    .flush_pc(flush_pc), .mc_start(mc_start), .mc_len(mc_len), .perf_clr(perf_clr), .stall(s_stall),
    .bubble(s_bubble), .flush(s_flush), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .stage_valid(s_stage_valid), .mc_busy(s_mc_busy), .mc_done(s_mc_done), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every output against the model for the current cycle and prepares the model's next state
  task automatic settle();
    logic [5:0] se;
    int s, f;
    bit as_, af, fw, sw, kill;
    #1;
    if (!rst) begin
      mv = '0; rem = 0; mdone = 0; msc = 0; mfc = 0; msc4 = 0; mfc4 = 0;
    end
    se = stallreq | ((rem > 0) ? 6'b001000 : 6'b000000);
    as_ = 0; af = 0; s = 0; f = 0;
    for (int i = 0; i < 6; i++) begin
      if (se[i]) begin s = i; as_ = 1; end
      if (flushreq[i]) begin f = i; af = 1; end
    end
    fw = rst && af && (!as_ || s <= f);
    sw = rst && as_ && !fw;
    check("stall", 64'(stall), sw ? 64'((1 << (s + 1)) - 1) : 64'd0);
    check("bubble", 64'(bubble), (sw && s < 5) ? 64'(1 << (s + 1)) : 64'd0);
    check("flush", 64'(flush), fw ? 64'((1 << (f + 1)) - 2) : 64'd0);
    check("redirect_valid", 64'(redirect_valid), 64'(fw));
    check("redirect_pc", 64'(redirect_pc), fw ? 64'(flush_pc[f*32 +: 32]) : 64'd0);
    check("stage_valid", 64'(stage_valid), 64'(mv));
    check("mc_busy", 64'(mc_busy), 64'(rem > 0));
    check("mc_done", 64'(mc_done), 64'(mdone));
    check("stall_cnt", 64'(stall_cnt), 64'(msc));
    check("flush_cnt", 64'(flush_cnt), 64'(mfc));
    check("stall_cnt4", 64'(s_stall_cnt), 64'(msc4));
    check("flush_cnt4", 64'(s_flush_cnt), 64'(mfc4));
    n_mv = {mv[4:0], 1'b1};
    if (sw) begin
      for (int j = 0; j <= s; j++) n_mv[j] = mv[j];
      if (s < 5) n_mv[s+1] = 1'b0;
    end
    if (fw) for (int j = 1; j <= f; j++) n_mv[j] = 1'b0;
    kill = fw && f >= 3;
    n_rem = 0; n_mdone = 0;
    if (kill || mdone) begin n_rem = 0; n_mdone = 0; end
    else if (rem > 0) begin n_rem = rem - 1; n_mdone = rem == 1; end
    else if (mc_start) begin
      if (mc_len == 0) n_mdone = 1;
      else n_rem = int'(mc_len);
    end
    n_msc  = perf_clr ? 0 : (sw && msc < 64'hFFFF_FFFF) ? msc + 1 : msc;
    n_mfc  = perf_clr ? 0 : (fw && mfc < 64'hFFFF_FFFF) ? mfc + 1 : mfc;
    n_msc4 = perf_clr ? 0 : (sw && msc4 < 15) ? msc4 + 1 : msc4;
    n_mfc4 = perf_clr ? 0 : (fw && mfc4 < 15) ? mfc4 + 1 : mfc4;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mv = n_mv; rem = n_rem; mdone = n_mdone; msc = n_msc; mfc = n_mfc; msc4 = n_msc4; mfc4 = n_mfc4;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin settle(); tick(); end
  endtask

  initial begin
    rst = 1'b0; stallreq = 6'h3f; flushreq = 6'h3f; flush_pc = '0;
    mc_start = 1'b1; mc_len = 8'd2; perf_clr = 1'b0;
    cyc(2);
    rst = 1'b1; stallreq = '0; flushreq = '0; mc_start = 1'b0;
    cyc(6);
    check("fill", 64'(stage_valid), 64'h3f);
    stallreq = 6'b000100;
    settle();
    check("stall_vec", 64'(stall), 64'b000111);
    check("bubble_vec", 64'(bubble), 64'b001000);
    tick();
    cyc(1);
    stallreq = '0;
    check("valid3_after_stall", 64'(stage_valid[3]), 64'd0);
    check("stall_cnt_2", 64'(stall_cnt), 64'd2);
    flush_pc[3*32 +: 32] = 32'hBFC0_0100;
    flushreq = 6'b001000;
    settle();
    check("flush_vec", 64'(flush), 64'b001110);
    check("redirect_pc_dir", 64'(redirect_pc), 64'hBFC0_0100);
    tick();
    flushreq = '0;
    check("valid_flushed", 64'(stage_valid[3:1]), 64'd0);
    check("flush_cnt_1", 64'(flush_cnt), 64'd1);
    stallreq = 6'b010000; flushreq = 6'b000100;
    settle();
    check("stall_beats_flush", 64'(redirect_valid), 64'd0);
    tick();
    stallreq = '0;
    settle();
    check("flush_after_drop", 64'(redirect_valid), 64'd1);
    tick();
    flushreq = '0;
    mc_start = 1'b1; mc_len = 8'd3;
    cyc(1);
    mc_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("mc3_busy", 64'(mc_busy), 64'd1);
      check("mc3_stall", 64'(stall), 64'b001111);
      tick();
    end
    settle();
    check("mc3_done", 64'(mc_done), 64'd1);
    tick();
    mc_start = 1'b1; mc_len = 8'd0;
    settle();
    check("mc0_nostall", 64'(stall), 64'd0);
    tick();
    mc_start = 1'b0;
    settle();
    check("mc0_done", 64'(mc_done), 64'd1);
    check("mc0_notbusy", 64'(mc_busy), 64'd0);
    tick();
    mc_start = 1'b1; mc_len = 8'd5;
    cyc(1);
    mc_start = 1'b0;
    cyc(2);
    flushreq = 6'b010000;
    settle();
    check("mc_abort_flush", 64'(flush), 64'b011110);
    tick();
    flushreq = '0;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("mc_abort_nodone", 64'(mc_done), 64'd0);
      check("mc_abort_idle", 64'(mc_busy), 64'd0);
      tick();
    end
    perf_clr = 1'b1;
    cyc(1);
    perf_clr = 1'b0; stallreq = 6'b000001;
    cyc(20);
    check("sat4_hold", 64'(s_stall_cnt), 64'hf);
    check("cnt32_20", 64'(stall_cnt), 64'd20);
    perf_clr = 1'b1;
    cyc(1);
    perf_clr = 1'b0; stallreq = '0;
    check("sat4_clr", 64'(s_stall_cnt), 64'd0);
    check("cnt32_clr", 64'(stall_cnt), 64'd0);
    for (int k = 0; k < 400; k++) begin
      stallreq = ($urandom % 4 == 0) ? 6'($urandom) : 6'd0;
      flushreq = ($urandom % 5 == 0) ? 6'($urandom) : 6'd0;
      mc_start = $urandom % 6 == 0;
      mc_len   = 8'($urandom % 7);
      perf_clr = $urandom % 60 == 0;
      for (int i = 0; i < 6; i++) flush_pc[i*32 +: 32] = $urandom;
      rst = !(k >= 200 && k < 202);
      cyc(1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
